// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle around mem_bus_arbiter: IFU and LSU request/response channels plus the memory port.
// master is the arbiter's own view; slave is the view of the requesters and memory attached to it.
interface mem_bus_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
           lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
           mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
           lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
           lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
           mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
           lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU, one transaction
// in flight, with a response timeout that turns a hung slave into an error response.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus,
  output logic              busy,
  output logic              grant_lsu
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  localparam logic        TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;
  logic [15:0] count_reg, count_next;

  // Channel values for whichever requester holds the grant; steered out below.
  logic        sel_req_ready;
  logic        sel_resp_valid;
  logic        sel_resp_err;
  logic [31:0] sel_rdata;
  logic        sel_resp_ready;
  logic        mem_req_valid_c;
  logic        mem_resp_ready_c;
  logic [31:0] mem_addr_c;
  logic        mem_wen_c;
  logic [31:0] mem_wdata_c;
  logic [7:0]  mem_wmask_c;

  assign sel_resp_ready = grant_reg ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      count_reg      <= 16'd0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_grant_next  = last_grant_reg;
    count_next       = count_reg;
    sel_req_ready    = 1'b0;
    sel_resp_valid   = 1'b0;
    sel_resp_err     = 1'b0;
    sel_rdata        = 32'd0;
    mem_req_valid_c  = 1'b0;
    mem_resp_ready_c = 1'b0;
    mem_addr_c       = 32'd0;
    mem_wen_c        = 1'b0;
    mem_wdata_c      = 32'd0;
    mem_wmask_c      = 8'd0;

    unique case (state_reg)
      IDLE: begin
        // Stray or late responses are swallowed here.
        mem_resp_ready_c = 1'b1;
        if (bus.ifu_req_valid || bus.lsu_req_valid) begin
          grant_next = (bus.ifu_req_valid && bus.lsu_req_valid) ? ~last_grant_reg
                                                                : bus.lsu_req_valid;
          count_next = 16'd0;
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_valid_c = 1'b1;
        sel_req_ready   = bus.mem_req_ready;
        mem_addr_c      = grant_reg ? bus.lsu_addr : bus.ifu_addr;
        mem_wen_c       = grant_reg & bus.lsu_wen;
        mem_wdata_c     = grant_reg ? bus.lsu_wdata : 32'd0;
        mem_wmask_c     = grant_reg ? bus.lsu_wmask : 8'd0;
        if (bus.mem_req_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        mem_resp_ready_c = sel_resp_ready;
        sel_resp_valid   = bus.mem_resp_valid;
        sel_rdata        = bus.mem_rdata;
        sel_resp_err     = bus.mem_resp_err;
        if (bus.mem_resp_valid) begin
          if (sel_resp_ready) begin
            last_grant_next = grant_reg;
            state_next      = IDLE;
          end
        end else begin
          count_next = count_reg + 16'd1;
          if (TIMEOUT_EN && (count_reg == TIMEOUT_LAST)) begin
            state_next = ERR;
          end
        end
      end
      ERR: begin
        mem_resp_ready_c = 1'b1;
        sel_resp_valid   = 1'b1;
        sel_resp_err     = 1'b1;
        if (sel_resp_ready) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.ifu_req_ready  = ~grant_reg & sel_req_ready;
  assign bus.lsu_req_ready  =  grant_reg & sel_req_ready;
  assign bus.ifu_resp_valid = ~grant_reg & sel_resp_valid;
  assign bus.lsu_resp_valid =  grant_reg & sel_resp_valid;
  assign bus.ifu_resp_err   = ~grant_reg & sel_resp_err;
  assign bus.lsu_resp_err   =  grant_reg & sel_resp_err;
  assign bus.ifu_rdata      = grant_reg ? 32'd0 : sel_rdata;
  assign bus.lsu_rdata      = grant_reg ? sel_rdata : 32'd0;

  assign bus.mem_req_valid  = mem_req_valid_c;
  assign bus.mem_resp_ready = mem_resp_ready_c;
  assign bus.mem_addr       = mem_addr_c;
  assign bus.mem_wen        = mem_wen_c;
  assign bus.mem_wdata      = mem_wdata_c;
  assign bus.mem_wmask      = mem_wmask_c;

  assign busy      = (state_reg != IDLE);
  assign grant_lsu = grant_reg;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: expected responses are queued when a request is driven
// and checked, in order, as the arbiter hands responses back to IFU or LSU.
module tb_mem_bus_arbiter;
  typedef struct packed {
    logic        is_lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic grant_lsu;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  int   req_wait    = 0;
  bit   hang        = 1'b0;
  bit   inject_late = 1'b0;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .grant_lsu (grant_lsu)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Memory model: request accepted after req_wait stall cycles, zero-wait response unless hung.
  initial begin : mem_model
    int          wcnt;
    logic        hs_req, hs_resp, inj;
    logic [31:0] a;
    wcnt = 0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = 32'd0;
    bus.mem_resp_err   = 1'b0;
    forever begin
      @(posedge clk);
      hs_req  = bus.mem_req_valid && bus.mem_req_ready;
      hs_resp = bus.mem_resp_valid && bus.mem_resp_ready;
      a       = bus.mem_addr;
      inj     = inject_late;
      #1;
      if (!rst) begin
        wcnt = 0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
      end else begin
        if (hs_resp) begin
          bus.mem_resp_valid = 1'b0;
          bus.mem_rdata      = 32'd0;
        end
        if (hs_req && !hang) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = rdata_for(a);
        end
        if (inj) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_rdata      = 32'hBAD0_BAD0;
        end
        if (bus.mem_req_valid) begin
          bus.mem_req_ready = (wcnt >= req_wait);
          wcnt++;
        end else begin
          bus.mem_req_ready = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  // Scoreboard side: every response handshake pops and checks the oldest expectation.
  initial begin : sb_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.ifu_resp_valid && bus.ifu_resp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_ifu: unexpected IFU response rdata=%h err=%b, required none", bus.ifu_rdata, bus.ifu_resp_err);
        end else begin
          e = sb.pop_front();
          if ({1'b0, bus.ifu_rdata, bus.ifu_resp_err} !== e) begin
            n_err++;
            $display("FAIL sb_ifu: got lsu=0 rdata=%h err=%b, required lsu=%b rdata=%h err=%b",
                     bus.ifu_rdata, bus.ifu_resp_err, e.is_lsu, e.rdata, e.err);
          end else begin
            $display("ifu resp rdata=%h err=%b", bus.ifu_rdata, bus.ifu_resp_err);
          end
        end
      end
      if (rst && bus.lsu_resp_valid && bus.lsu_resp_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_lsu: unexpected LSU response rdata=%h err=%b, required none", bus.lsu_rdata, bus.lsu_resp_err);
        end else begin
          e = sb.pop_front();
          if ({1'b1, bus.lsu_rdata, bus.lsu_resp_err} !== e) begin
            n_err++;
            $display("FAIL sb_lsu: got lsu=1 rdata=%h err=%b, required lsu=%b rdata=%h err=%b",
                     bus.lsu_rdata, bus.lsu_resp_err, e.is_lsu, e.rdata, e.err);
          end else begin
            $display("lsu resp rdata=%h err=%b", bus.lsu_rdata, bus.lsu_resp_err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h0000_1000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h0000_2000;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'd0;
    bus.lsu_wmask     = 8'd0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid,
           bus.mem_req_valid, bus.mem_resp_ready, busy, grant_lsu} !== 8'b0000_0100) begin
        n_err++;
        $display("FAIL reset_ctl: got %b, required 00000100", {bus.ifu_req_ready, bus.lsu_req_ready,
                 bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid, bus.mem_resp_ready, busy, grant_lsu});
      end
      n_cmp++;
      if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen, bus.ifu_rdata, bus.lsu_rdata} !== '0) begin
        n_err++;
        $display("FAIL reset_payload: got addr=%h wdata=%h wmask=%h, required zeros",
                 bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset released with both requesters valid");
  endtask

  task automatic test_round_robin();
    int n_i = 0;
    int n_l = 0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) sb.push_back(exp_t'{1'b1, rdata_for(32'h0000_2000 + 32'(4 * (k / 2))), 1'b0});
      else            sb.push_back(exp_t'{1'b0, rdata_for(32'h0000_1000 + 32'(4 * (k / 2))), 1'b0});
    end
    for (int c = 0; c < 200 && (n_i < 3 || n_l < 3); c++) begin
      logic ir, lr;
      @(negedge clk);
      ir = bus.ifu_req_ready;
      lr = bus.lsu_req_ready;
      if (ir || lr) begin
        n_cmp++;
        if ({ir, lr} !== (((n_i + n_l) % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL rr_order: transaction %0d got ifu_ready=%b lsu_ready=%b, required %s",
                   n_i + n_l, ir, lr, ((n_i + n_l) % 2 == 0) ? "LSU" : "IFU");
        end else begin
          $display("rr transaction %0d granted to %s", n_i + n_l, lr ? "LSU" : "IFU");
        end
      end
      @(posedge clk);
      #1;
      if (ir) begin
        n_i++;
        if (n_i == 3) bus.ifu_req_valid = 1'b0;
        else          bus.ifu_addr = 32'h0000_1000 + 32'(4 * n_i);
      end
      if (lr) begin
        n_l++;
        if (n_l == 3) bus.lsu_req_valid = 1'b0;
        else          bus.lsu_addr = 32'h0000_2000 + 32'(4 * n_l);
      end
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    n_cmp++;
    if (n_i != 3 || n_l != 3) begin
      n_err++;
      $display("FAIL rr_count: got ifu=%0d lsu=%0d accepted, required 3 and 3", n_i, n_l);
    end
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rr_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_ifu();
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    sb.push_back(exp_t'{1'b0, 32'h0000_0413, 1'b0});
    @(negedge clk);
    n_cmp++;
    if ({busy, bus.ifu_req_ready, bus.mem_req_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL ifu_idle: got busy/ready/mem_valid=%b, required 000", {busy, bus.ifu_req_ready, bus.mem_req_valid});
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, grant_lsu, bus.mem_req_valid, bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_wen,
         bus.mem_resp_ready} !== 7'b1011000) begin
      n_err++;
      $display("FAIL ifu_req_ctl: got %b, required 1011000", {busy, grant_lsu, bus.mem_req_valid,
               bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_wen, bus.mem_resp_ready});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== {32'h8000_0000, 32'h0, 8'h0}) begin
      n_err++;
      $display("FAIL ifu_req_payload: got addr=%h wdata=%h wmask=%h, required 80000000/0/0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_resp_err, bus.lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL ifu_resp: got valid=%b rdata=%h err=%b lsu_valid=%b, required 1/00000413/0/0",
               bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_resp_err, bus.lsu_resp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ifu_done: got busy=%b three cycles after valid, required 0", busy);
    end
  endtask

  task automatic test_write_stall();
    int req_cycles = 0;
    bit accepted   = 1'b0;
    req_wait = 4;
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_1000;
    bus.lsu_wen       = 1'b1;
    bus.lsu_wdata     = 32'hDEAD_BEEF;
    bus.lsu_wmask     = 8'h0F;
    sb.push_back(exp_t'{1'b1, rdata_for(32'h8000_1000), 1'b0});
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        req_cycles++;
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !== {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F}) begin
          n_err++;
          $display("FAIL wr_payload: REQ cycle %0d got addr=%h wen=%b wdata=%h wmask=%h, required 80001000/1/deadbeef/0f",
                   req_cycles, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
        end
        n_cmp++;
        if ({bus.lsu_req_ready, bus.ifu_req_ready} !== {(req_cycles == 5), 1'b0}) begin
          n_err++;
          $display("FAIL wr_ready: REQ cycle %0d got lsu_ready=%b ifu_ready=%b, required %b/0",
                   req_cycles, bus.lsu_req_ready, bus.ifu_req_ready, (req_cycles == 5));
        end
        if (bus.lsu_req_ready) accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = 32'd0;
    bus.lsu_wmask     = 8'd0;
    req_wait = 0;
    n_cmp++;
    if (req_cycles != 5) begin
      n_err++;
      $display("FAIL wr_req_cycles: got %0d REQ cycles, required 5", req_cycles);
    end else begin
      $display("lsu write accepted after %0d REQ cycles", req_cycles);
    end
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wr_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_timeout();
    int resp_cycles = 0;
    hang = 1'b1;
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = 32'h8000_2000;
    sb.push_back(exp_t'{1'b1, 32'h0, 1'b1});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.lsu_req_ready) break;
    end
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy || bus.lsu_resp_valid) break;
      resp_cycles++;
    end
    n_cmp++;
    if (resp_cycles != 8) begin
      n_err++;
      $display("FAIL to_cycles: got %0d RESP cycles before error, required 8", resp_cycles);
    end
    n_cmp++;
    if ({bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_rdata, bus.mem_resp_ready, bus.ifu_resp_valid} !==
        {1'b1, 1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL to_err: got valid=%b err=%b rdata=%h mem_resp_ready=%b ifu_valid=%b, required 1/1/0/1/0",
               bus.lsu_resp_valid, bus.lsu_resp_err, bus.lsu_rdata, bus.mem_resp_ready, bus.ifu_resp_valid);
    end
    hang = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_idle: got busy=%b after error handshake, required 0", busy);
    end
    @(posedge clk);
    #1;
    inject_late = 1'b1;
    @(posedge clk);
    #2;
    inject_late = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 4'b0100) begin
      n_err++;
      $display("FAIL late_drop: got busy/mem_resp_ready/ifu_valid/lsu_valid=%b, required 0100",
               {busy, bus.mem_resp_ready, bus.ifu_resp_valid, bus.lsu_resp_valid});
    end
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 32'h8000_0000;
    sb.push_back(exp_t'{1'b0, 32'h0000_0413, 1'b0});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ifu_req_ready) break;
    end
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_recover: got busy=%b after follow-up read, required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 32'h0000_3000;
    bus.ifu_resp_ready = 1'b0;
    sb.push_back(exp_t'{1'b0, rdata_for(32'h0000_3000), 1'b0});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ifu_req_ready) break;
    end
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, bus.mem_resp_valid, bus.mem_resp_ready, bus.ifu_resp_valid} !== 4'b1101) begin
        n_err++;
        $display("FAIL bp_hold: stall cycle %0d got busy/mem_valid/mem_ready/ifu_valid=%b, required 1101",
                 c, {busy, bus.mem_resp_valid, bus.mem_resp_ready, bus.ifu_resp_valid});
      end
    end
    @(posedge clk);
    #1;
    bus.ifu_resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, bus.mem_resp_ready, bus.ifu_resp_valid, bus.ifu_rdata} !== {1'b1, 1'b1, 1'b1, rdata_for(32'h0000_3000)}) begin
      n_err++;
      $display("FAIL bp_release: got busy=%b mem_ready=%b valid=%b rdata=%h, required 1/1/1/%h",
               busy, bus.mem_resp_ready, bus.ifu_resp_valid, bus.ifu_rdata, rdata_for(32'h0000_3000));
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: got busy=%b, required 0", busy);
    end
  endtask

  initial begin
    rst                = 1'b0;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = 32'd0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = 32'd0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = 32'd0;
    bus.lsu_wmask      = 8'd0;
    bus.lsu_resp_ready = 1'b1;

    test_reset();
    test_round_robin();
    test_single_ifu();
    test_write_stall();
    test_timeout();
    test_backpressure();

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d responses still outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
